// File: rtl/out_fm_fifo_to_tile_buf_pkg.sv
// Shared accelerator definitions: default widths and strides, plus the
// tile-store FSM encoding.
package out_fm_fifo_to_tile_buf_pkg;

    localparam int ACC_DW         = 32;
    localparam int ACC_CW         = 16;
    localparam int ACC_BAW        = 14;
    localparam int ACC_TR         = 64;
    localparam int ACC_TC         = 16;
    localparam int ACC_FIFO_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } tile_state_e;

endpackage

// File: rtl/out_fm_fifo_to_tile_buf_fifo.sv
// Synchronous FIFO with a registered occupancy count. Read data is taken
// combinationally from the head entry, so a word is visible the cycle after its push.
module sync_fifo_cnt #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/out_fm_fifo_to_tile_buf.sv
// Drains output-feature-map words from a local FIFO into the tile buffer,
// walking c, then r, then m, with addresses built from running bases.
module out_fm_fifo_to_tile_buf
    import out_fm_fifo_to_tile_buf_pkg::*;
#(
    parameter int DW         = ACC_DW,
    parameter int CW         = ACC_CW,
    parameter int BAW        = ACC_BAW,
    parameter int Tr         = ACC_TR,
    parameter int Tc         = ACC_TC,
    parameter int FIFO_DEPTH = ACC_FIFO_DEPTH,
    parameter int AF_TH      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DW-1:0]  load_data,
    input  logic           load_fifo_push,
    output logic           load_fifo_almost_full,
    input  logic           store_start,
    input  logic [CW-1:0]  cfg_tm,
    input  logic [CW-1:0]  cfg_tr,
    input  logic [CW-1:0]  cfg_tc,
    output logic           buf_wr_en,
    output logic [BAW-1:0] buf_wr_addr,
    output logic [DW-1:0]  buf_wr_data,
    output logic           store_done,
    output logic           busy,
    output logic           fifo_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    AF_LEVEL   = (AW+1)'(FIFO_DEPTH - AF_TH);
    localparam logic [BAW-1:0] ROW_STEP   = BAW'(Tc);
    localparam logic [BAW-1:0] PLANE_STEP = BAW'(Tr * Tc);

    tile_state_e    state_q, state_d;
    logic [CW-1:0]  tm_q, tr_q, tc_q;
    logic [CW-1:0]  m_q, m_d, r_q, r_d, c_q, c_d;
    logic [BAW-1:0] plane_q, plane_d, row_q, row_d;
    logic           wr_en_q;
    logic [BAW-1:0] wr_addr_q;
    logic [DW-1:0]  wr_data_q;
    logic           ovf_q;

    logic           pop;
    logic [DW-1:0]  fifo_rdata;
    logic [AW:0]    fifo_count;
    logic           fifo_full, fifo_empty;

    sync_fifo_cnt #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (load_fifo_push),
        .wdata_i (load_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        c_d     = c_q;
        plane_d = plane_q;
        row_d   = row_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (store_start) begin
                    m_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    plane_d = '0;
                    row_d   = '0;
                    state_d = (cfg_tm == '0 || cfg_tr == '0 || cfg_tc == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (c_q != tc_q - CW'(1)) begin
                        c_d = c_q + CW'(1);
                    end else begin
                        c_d = '0;
                        if (r_q != tr_q - CW'(1)) begin
                            r_d   = r_q + CW'(1);
                            row_d = row_q + ROW_STEP;
                        end else begin
                            // Next channel plane: both bases jump to the new plane origin.
                            r_d     = '0;
                            plane_d = plane_q + PLANE_STEP;
                            row_d   = plane_q + PLANE_STEP;
                            if (m_q == tm_q - CW'(1)) state_d = ST_DONE;
                            else                      m_d     = m_q + CW'(1);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tm_q      <= '0;
            tr_q      <= '0;
            tc_q      <= '0;
            m_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            plane_q   <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            c_q     <= c_d;
            plane_q <= plane_d;
            row_q   <= row_d;
            if (state_q == ST_IDLE && store_start) begin
                tm_q <= cfg_tm;
                tr_q <= cfg_tr;
                tc_q <= cfg_tc;
            end
            wr_en_q <= pop;
            if (pop) begin
                wr_addr_q <= row_q + BAW'(c_q);
                wr_data_q <= fifo_rdata;
            end
            if (load_fifo_push && fifo_full) ovf_q <= 1'b1;
        end
    end

    assign load_fifo_almost_full = (fifo_count >= AF_LEVEL);
    assign buf_wr_en             = wr_en_q;
    assign buf_wr_addr           = wr_addr_q;
    assign buf_wr_data           = wr_data_q;
    assign store_done            = (state_q == ST_DONE);
    assign busy                  = (state_q != ST_IDLE);
    assign fifo_overflow         = ovf_q;

endmodule

// File: tb/tb_out_fm_fifo_to_tile_buf.sv
// Directed bench for out_fm_fifo_to_tile_buf with a write scoreboard:
// stimulus queues expected writes, a monitor branch pops and compares them.
module tb_out_fm_fifo_to_tile_buf;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int BAW = 14;

    typedef struct {
        logic [BAW-1:0] addr;
        logic [DW-1:0]  data;
        logic           done;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  load_data = '0;
    logic           load_fifo_push = 1'b0;
    logic           load_fifo_almost_full;
    logic           store_start = 1'b0;
    logic [CW-1:0]  cfg_tm = '0, cfg_tr = '0, cfg_tc = '0;
    logic           buf_wr_en;
    logic [BAW-1:0] buf_wr_addr;
    logic [DW-1:0]  buf_wr_data;
    logic           store_done;
    logic           busy;
    logic           fifo_overflow;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   allow_bare_done = 1'b0;
    exp_t exp_q[$];

    out_fm_fifo_to_tile_buf dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .load_data             (load_data),
        .load_fifo_push        (load_fifo_push),
        .load_fifo_almost_full (load_fifo_almost_full),
        .store_start           (store_start),
        .cfg_tm                (cfg_tm),
        .cfg_tr                (cfg_tr),
        .cfg_tc                (cfg_tc),
        .buf_wr_en             (buf_wr_en),
        .buf_wr_addr           (buf_wr_addr),
        .buf_wr_data           (buf_wr_data),
        .store_done            (store_done),
        .busy                  (busy),
        .fifo_overflow         (fifo_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input int addr, input logic [DW-1:0] data, input logic done, input int c);
        exp_t e;
        e.addr = BAW'(addr);
        e.data = data;
        e.done = done;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        load_data      = d;
        load_fifo_push = 1'b1;
        @(posedge clk); #1;
        load_fifo_push = 1'b0;
    endtask

    task automatic start_tile(input int tm, input int tr, input int tc);
        store_start = 1'b1;
        cfg_tm = CW'(tm);
        cfg_tr = CW'(tr);
        cfg_tc = CW'(tc);
        @(posedge clk); #1;
        store_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, 64'(n >= budget), 64'(0));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && buf_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%0d data=%0h required=no write",
                             buf_wr_addr, buf_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(buf_wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(buf_wr_data), 64'(e.data));
                    chk("wr_store_done", 64'(store_done), 64'(e.done));
                    if (e.cyc >= 0) chk("wr_latency", 64'(cyc), 64'(e.cyc));
                end
            end else if (rst_n && store_done) begin
                chk("bare_store_done", 64'(allow_bare_done), 64'(1));
            end
        end
    endtask

    task automatic stimulus();
        int a;
        // Reset state
        #2;
        chk("rst_wr_en", 64'(buf_wr_en), 0);
        chk("rst_done", 64'(store_done), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_af", 64'(load_fifo_almost_full), 0);
        chk("rst_ovf", 64'(fifo_overflow), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 2/2/4 tile, words pushed after start; a second start mid-tile is ignored
        start_tile(2, 2, 4);
        chk("t1_busy", 64'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            a = (i / 8) * 1024 + ((i / 4) % 2) * 16 + (i % 4);
            expect_wr(a, DW'(32'hA000 + i), i == 15, -1);
            if (i == 4) begin
                store_start = 1'b1;
                cfg_tm = 1; cfg_tr = 1; cfg_tc = 1;
            end
            push_word(DW'(32'hA000 + i));
            store_start = 1'b0;
        end
        wait_idle("t1", 100);

        // Almost-full threshold at 60 entries, cleared by draining
        for (int i = 0; i < 61; i++) begin
            expect_wr(i, DW'(32'hB000 + i), i == 60, -1);
            push_word(DW'(32'hB000 + i));
            if (i == 58) chk("t2_af_59", 64'(load_fifo_almost_full), 0);
            if (i == 59) chk("t2_af_60", 64'(load_fifo_almost_full), 1);
        end
        chk("t2_af_61", 64'(load_fifo_almost_full), 1);
        chk("t2_idle_busy", 64'(busy), 0);
        start_tile(1, 1, 61);
        wait_idle("t2", 200);
        chk("t2_af_drained", 64'(load_fifo_almost_full), 0);

        // Overflow: 65th push dropped, sticky flag
        for (int i = 0; i < 65; i++) begin
            if (i < 64) expect_wr(i, DW'(32'hC000 + i), i == 63, -1);
            push_word(DW'(32'hC000 + i));
            if (i == 63) begin
                chk("t3_ovf_64", 64'(fifo_overflow), 0);
                chk("t3_af_full", 64'(load_fifo_almost_full), 1);
            end
        end
        chk("t3_ovf_65", 64'(fifo_overflow), 1);
        start_tile(1, 1, 64);
        wait_idle("t3", 200);
        chk("t3_ovf_sticky", 64'(fifo_overflow), 1);

        // Zero-size tile
        allow_bare_done = 1'b1;
        start_tile(2, 0, 4);
        chk("t4_done", 64'(store_done), 1);
        chk("t4_busy", 64'(busy), 1);
        @(posedge clk); #1;
        chk("t4_done_drop", 64'(store_done), 0);
        chk("t4_busy_drop", 64'(busy), 0);
        allow_bare_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-tile, then a fresh 1/1/3 tile
        start_tile(1, 1, 16);
        for (int i = 0; i < 5; i++) begin
            expect_wr(i, DW'(32'hD000 + i), 1'b0, -1);
            push_word(DW'(32'hD000 + i));
        end
        a = 0;
        while (exp_q.size() != 0 && a < 50) begin
            @(posedge clk); #1;
            a++;
        end
        chk("t5_pre_timeout", 64'(a >= 50), 0);
        load_data = 32'hDEADBEEF;
        load_fifo_push = 1'b1;
        @(posedge clk); #1;
        load_fifo_push = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", 64'(buf_wr_en), 0);
        chk("t5_rst_addr", 64'(buf_wr_addr), 0);
        chk("t5_rst_data", 64'(buf_wr_data), 0);
        chk("t5_rst_done", 64'(store_done), 0);
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_af", 64'(load_fifo_almost_full), 0);
        chk("t5_rst_ovf", 64'(fifo_overflow), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start_tile(1, 1, 3);
        for (int i = 0; i < 3; i++) begin
            expect_wr(i, DW'(32'hE000 + i), i == 2, -1);
            push_word(DW'(32'hE000 + i));
        end
        wait_idle("t5", 50);

        // Sparse pushes: each word popped immediately, written one cycle later
        start_tile(1, 1, 8);
        for (int i = 0; i < 8; i++) begin
            expect_wr(i, DW'(32'hF000 + i), i == 7, cyc + 2);
            push_word(DW'(32'hF000 + i));
            @(posedge clk); #1;
        end
        wait_idle("t6", 50);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_fm_fifo_to_tile_buf.md
OUT_FM_FIFO_TO_TILE_BUF -- requirements
Module: out_fm_fifo_to_tile_buf

Interface
REQ-001 Parameter DW, default 32, data word width.
REQ-002 Parameter CW, default 16, configuration count width.
REQ-003 Parameter BAW, default 14, tile-buffer address width.
REQ-004 Parameter Tr, default 64, buffer row stride in tile rows.
REQ-005 Parameter Tc, default 16, buffer column stride in words.
REQ-006 Parameter FIFO_DEPTH, default 64, entries (power of two).
REQ-007 Parameter AF_TH, default 4, almost-full slack in entries.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 load_data  input  DW  word from upstream read-master unpacker.
REQ-011 load_fifo_push  input  1  write strobe for load_data.
REQ-012 load_fifo_almost_full  output  1  back-pressure to upstream.
REQ-013 store_start  input  1  one-cycle pulse beginning a tile transfer.
REQ-014 cfg_tm, cfg_tr, cfg_tc  input  CW each  valid channels/rows/cols of this tile.
REQ-015 buf_wr_en  output  1  tile-buffer write strobe.
REQ-016 buf_wr_addr  output  BAW  tile-buffer word address.
REQ-017 buf_wr_data  output  DW  tile-buffer write data.
REQ-018 store_done  output  1  one-cycle pulse, tile completely written.
REQ-019 busy  output  1  high from accepted start until store_done.
REQ-020 fifo_overflow  output  1  sticky, a push was dropped.

Function
REQ-021 Internal FIFO SHALL hold FIFO_DEPTH words with a registered occupancy count; wrap-around of read/write pointers modulo FIFO_DEPTH.
REQ-022 Push SHALL be accepted iff load_fifo_push=1 and count<FIFO_DEPTH; otherwise the word is dropped and fifo_overflow set until reset.
REQ-023 load_fifo_almost_full SHALL be registered-count based: high when count >= FIFO_DEPTH-AF_TH.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; a word pushed in cycle t is poppable no earlier than t+1.
REQ-025 FSM states IDLE, DRAIN, DONE; reset state IDLE.
REQ-026 IDLE: store_start=1 latches cfg_tm/tr/tc, clears m/r/c counters, goes to DRAIN; if any cfg field is 0, goes to DONE instead.
REQ-027 store_start outside IDLE SHALL be ignored.
REQ-028 DRAIN: pop when FIFO non-empty; never pop when empty.
REQ-029 Word popped in cycle t SHALL appear with buf_wr_en=1 in cycle t+1; buf_wr_en=0 otherwise.
REQ-030 Address SHALL equal m*Tr*Tc + r*Tc + c, formed by incremental adders (no multiplier), truncated to BAW bits.
REQ-031 Traversal order c fastest, then r, then m; c wraps at cfg_tc, r at cfg_tr, m at cfg_tm.
REQ-032 After the pop of word (cfg_tm*cfg_tr*cfg_tc)-1, FSM goes to DONE; DONE asserts store_done for one cycle coincident with the final buf_wr_en, then IDLE.
REQ-033 Zero-size tile: store_done one cycle after store_start, no buffer writes.
REQ-034 Words remaining in FIFO after store_done SHALL be retained for the next tile.
REQ-035 busy SHALL be 1 in DRAIN and DONE, 0 in IDLE.

Reset
REQ-036 On rst_n=0, immediately: FSM IDLE, count and pointers 0, counters 0, all outputs 0 (load_fifo_almost_full 0, fifo_overflow 0).
REQ-037 Reset mid-transfer SHALL discard FIFO contents and partial tile; no write after rst_n deasserts until new store_start.
REQ-038 FIFO storage array needs no reset.

Structure
REQ-039 FSM state encoding and default DW/CW/BAW/Tr/Tc/FIFO_DEPTH SHALL live in the shared accelerator package.
REQ-040 FIFO SHALL be one sub-module, sync_fifo_cnt (push, pop, data, count, full, empty); address generation and FSM stay in the top.

Verification
REQ-041 cfg 2/2/4, 16 words pushed back-to-back after start -> 16 writes, addresses 0-3,16-19,1024-1027,1040-1043, store_done on 16th write.
REQ-042 Push 61 words with no start -> load_fifo_almost_full=1 at count 60, 0 after start drains below 60.
REQ-043 Push 65 words while IDLE -> fifo_overflow=1, count=64, 65th word never written.
REQ-044 cfg_tr=0 -> store_done one cycle after start, buf_wr_en never asserted.
REQ-045 rst_n low mid-tile after 5 writes -> outputs 0 immediately; new start, cfg 1/1/3 -> writes addresses 0,1,2 with fresh data only.
REQ-046 Push every other cycle with simultaneous pops, cfg 1/1/8 -> count stays <=1, 8 in-order writes, each 1 cycle after its pop.
